// File: rtl/mm_pkg.sv
// Shared constants and types for the matrix-multiply engine.
package mm_pkg;

  localparam int W        = 8;
  localparam int ACCW     = 32;
  localparam int T        = 16;
  localparam int SIGNED_M = 1;
  localparam int PIPE_MUL = 1;

  typedef logic [W-1:0]    opnd_t;
  typedef logic [ACCW-1:0] acc_t;

  // Full 2W-bit product, then extended to accumulator width. Operands are
  // widened by hand so the multiply is done at 2W bits in both modes.
  function automatic acc_t ext_product(input opnd_t a, input opnd_t b, input logic sgn);
    logic [2*W-1:0] wa;
    logic [2*W-1:0] wb;
    logic [2*W-1:0] p;
    wa = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    wb = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = wa * wb;
    return sgn ? {{(ACCW-2*W){p[2*W-1]}}, p} : {{(ACCW-2*W){1'b0}}, p};
  endfunction

endpackage

// File: rtl/mac_pe.sv
// One processing element: forwards a east and b south, multiplies the local
// operand pair, accumulates, and snapshots the running sum on drain.
module mac_pe
  import mm_pkg::*;
#(
  parameter int SIGNED_OPS = SIGNED_M,
  parameter int PIPE_STAGE = PIPE_MUL
) (
  input  logic  clk,
  input  logic  rst,
  input  opnd_t a_west,
  input  logic  a_west_valid,
  input  opnd_t b_north,
  input  logic  b_north_valid,
  input  logic  acc_clear,
  input  logic  drain,
  output opnd_t a_east,
  output logic  a_east_valid,
  output opnd_t b_south,
  output logic  b_south_valid,
  output acc_t  snap,
  output logic  snap_valid
);

  acc_t product;
  acc_t addend;
  logic add_valid;
  acc_t acc;
  acc_t acc_sum;

  assign product = ext_product(a_west, b_north, SIGNED_OPS != 0);

  generate
    if (PIPE_STAGE != 0) begin : g_pipe
      acc_t prod_q;
      logic prod_valid_q;

      // Product register: the add happens one cycle after the operands meet.
      always_ff @(posedge clk) begin
        if (rst) begin
          prod_q       <= '0;
          prod_valid_q <= 1'b0;
        end else begin
          prod_q       <= product;
          prod_valid_q <= a_west_valid & b_north_valid;
        end
      end

      assign addend    = prod_q;
      assign add_valid = prod_valid_q;
    end else begin : g_comb
      assign addend    = product;
      assign add_valid = a_west_valid & b_north_valid;
    end
  endgenerate

  // Value including any product landing this edge; also what a drain captures.
  assign acc_sum = acc + (add_valid ? addend : '0);

  // Operand forwarding, one hop per cycle regardless of validity.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_east        <= '0;
      a_east_valid  <= 1'b0;
      b_south       <= '0;
      b_south_valid <= 1'b0;
    end else begin
      a_east        <= a_west;
      a_east_valid  <= a_west_valid;
      b_south       <= b_north;
      b_south_valid <= b_north_valid;
    end
  end

  // Accumulator: a clear still keeps a coincident product (clear-then-add).
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (acc_clear) begin
      acc <= add_valid ? addend : '0;
    end else begin
      acc <= acc_sum;
    end
  end

  // Snapshot register: captures the pre-clear sum, valid for one cycle per drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap       <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= drain;
      if (drain) begin
        snap <= acc_sum;
      end
    end
  end

endmodule

// File: rtl/pe_systolic_array.sv
// Output-stationary N x N systolic MAC array. A flows right along rows,
// B flows down columns; input skew is the caller's responsibility.
module pe_systolic_array
  import mm_pkg::*;
#(
  parameter int N          = T,
  parameter int SIGNED_OPS = SIGNED_M,
  parameter int PIPE_STAGE = PIPE_MUL
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N-1:0][W-1:0]           a_in_row,
  input  logic [N-1:0]                  a_in_valid,
  input  logic [N-1:0][W-1:0]           b_in_col,
  input  logic [N-1:0]                  b_in_valid,
  input  logic                          acc_clear_block,
  input  logic                          drain_pulse,
  output logic [N-1:0][N-1:0][ACCW-1:0] acc_mat,
  output logic [N-1:0][N-1:0]           acc_v_mat
);

  opnd_t a_bus  [N][N+1];
  logic  a_vbus [N][N+1];
  opnd_t b_bus  [N+1][N];
  logic  b_vbus [N+1][N];
  logic  unused_edge;

  genvar i, j;
  generate
    for (i = 0; i < N; i++) begin : g_edge
      assign a_bus[i][0]  = a_in_row[i];
      assign a_vbus[i][0] = a_in_valid[i];
      assign b_bus[0][i]  = b_in_col[i];
      assign b_vbus[0][i] = b_in_valid[i];
    end

    for (i = 0; i < N; i++) begin : g_row
      for (j = 0; j < N; j++) begin : g_col
        mac_pe #(
          .SIGNED_OPS(SIGNED_OPS),
          .PIPE_STAGE(PIPE_STAGE)
        ) u_pe (
          .clk          (clk),
          .rst          (rst),
          .a_west       (a_bus[i][j]),
          .a_west_valid (a_vbus[i][j]),
          .b_north      (b_bus[i][j]),
          .b_north_valid(b_vbus[i][j]),
          .acc_clear    (acc_clear_block),
          .drain        (drain_pulse),
          .a_east       (a_bus[i][j+1]),
          .a_east_valid (a_vbus[i][j+1]),
          .b_south      (b_bus[i+1][j]),
          .b_south_valid(b_vbus[i+1][j]),
          .snap         (acc_mat[i][j]),
          .snap_valid   (acc_v_mat[i][j])
        );
      end
    end
  endgenerate

  // Operands leaving the far edges go nowhere; fold them into one sink.
  always_comb begin
    unused_edge = 1'b0;
    for (int k = 0; k < N; k++) begin
      unused_edge = unused_edge ^ (^{a_bus[k][N], a_vbus[k][N], b_bus[N][k], b_vbus[N][k]});
    end
  end

endmodule

// File: tb/tb_pe_systolic_array.sv
// Self-checking bench: random and directed tiles against a matrix-level model.
module tb_pe_systolic_array;
  import mm_pkg::*;

  localparam int KMAX = 24;
  localparam int UN   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst;
  logic [T-1:0][W-1:0]           a_in_row;
  logic [T-1:0]                  a_in_valid;
  logic [T-1:0][W-1:0]           b_in_col;
  logic [T-1:0]                  b_in_valid;
  logic                          acc_clear_block;
  logic                          drain_pulse;
  logic [T-1:0][T-1:0][ACCW-1:0] acc_mat;
  logic [T-1:0][T-1:0]           acc_v_mat;

  logic [UN-1:0][W-1:0]            u_a_in_row;
  logic [UN-1:0]                   u_a_in_valid;
  logic [UN-1:0][W-1:0]            u_b_in_col;
  logic [UN-1:0]                   u_b_in_valid;
  logic                            u_acc_clear_block;
  logic                            u_drain_pulse;
  logic [UN-1:0][UN-1:0][ACCW-1:0] u_acc_mat;
  logic [UN-1:0][UN-1:0]           u_acc_v_mat;

  pe_systolic_array dut (
    .clk(clk), .rst(rst),
    .a_in_row(a_in_row), .a_in_valid(a_in_valid),
    .b_in_col(b_in_col), .b_in_valid(b_in_valid),
    .acc_clear_block(acc_clear_block), .drain_pulse(drain_pulse),
    .acc_mat(acc_mat), .acc_v_mat(acc_v_mat)
  );

  pe_systolic_array #(.N(UN), .SIGNED_OPS(0), .PIPE_STAGE(0)) dut_u (
    .clk(clk), .rst(rst),
    .a_in_row(u_a_in_row), .a_in_valid(u_a_in_valid),
    .b_in_col(u_b_in_col), .b_in_valid(u_b_in_valid),
    .acc_clear_block(u_acc_clear_block), .drain_pulse(u_drain_pulse),
    .acc_mat(u_acc_mat), .acc_v_mat(u_acc_v_mat)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0]    a_m  [T][KMAX];
  bit              av_m [T][KMAX];
  logic [W-1:0]    b_m  [KMAX][T];
  bit              bv_m [KMAX][T];
  logic [ACCW-1:0] exp_c [T][T];
  logic [T-1:0][T-1:0] all_ones;
  logic [UN-1:0][UN-1:0] u_all_ones;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ACCW-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    longint pa;
    longint pb;
    longint p;
    pa = sgn ? longint'($signed(a)) : longint'(a);
    pb = sgn ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    return p[ACCW-1:0];
  endfunction

  task automatic idle_inputs();
    for (int i = 0; i < T; i++) begin
      a_in_row[i] = W'($urandom);
      b_in_col[i] = W'($urandom);
    end
    a_in_valid      = '0;
    b_in_valid      = '0;
    acc_clear_block = 1'b0;
    drain_pulse     = 1'b0;
  endtask

  task automatic u_idle();
    for (int i = 0; i < UN; i++) begin
      u_a_in_row[i] = W'($urandom);
      u_b_in_col[i] = W'($urandom);
    end
    u_a_in_valid      = '0;
    u_b_in_valid      = '0;
    u_acc_clear_block = 1'b0;
    u_drain_pulse     = 1'b0;
  endtask

  task automatic clear_mats();
    for (int i = 0; i < T; i++)
      for (int k = 0; k < KMAX; k++) begin
        a_m[i][k] = '0; av_m[i][k] = 1'b0;
        b_m[k][i] = '0; bv_m[k][i] = 1'b0;
      end
  endtask

  // C = sum over k of A[i][k]*B[k][j] wherever both operands were marked valid.
  task automatic compute_model(input int k_len);
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++) begin
        exp_c[i][j] = '0;
        for (int k = 0; k < k_len; k++)
          if (av_m[i][k] && bv_m[k][j])
            exp_c[i][j] = exp_c[i][j] + ref_prod(a_m[i][k], b_m[k][j], SIGNED_M != 0);
      end
  endtask

  // Skewed feed: row i gets A[i][c-i], column j gets B[c-j][j] in cycle c.
  task automatic drive_cycle(input int c, input int k_len);
    int k;
    for (int i = 0; i < T; i++) begin
      k = c - i;
      if (k >= 0 && k < k_len && av_m[i][k]) begin
        a_in_row[i] = a_m[i][k]; a_in_valid[i] = 1'b1;
      end else begin
        a_in_row[i] = W'($urandom); a_in_valid[i] = 1'b0;
      end
      if (k >= 0 && k < k_len && bv_m[k][i]) begin
        b_in_col[i] = b_m[k][i]; b_in_valid[i] = 1'b1;
      end else begin
        b_in_col[i] = W'($urandom); b_in_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic feed_tile(input int k_len, input bit do_clear);
    idle_inputs();
    if (do_clear) begin
      acc_clear_block = 1'b1;
      step();
      acc_clear_block = 1'b0;
    end
    for (int c = 0; c < k_len + T - 1; c++) begin
      drive_cycle(c, k_len);
      step();
    end
    idle_inputs();
    repeat (T + 2) step();
  endtask

  task automatic do_drain();
    drain_pulse = 1'b1;
    step();
    drain_pulse = 1'b0;
  endtask

  task automatic set_identity_ramp();
    clear_mats();
    for (int i = 0; i < T; i++)
      for (int k = 0; k < T; k++) begin
        a_m[i][k] = (i == k) ? W'(1) : W'(0); av_m[i][k] = 1'b1;
        b_m[k][i] = W'(i);                    bv_m[k][i] = 1'b1;
      end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < T; i++) begin
      a_in_row[i] = W'($urandom); b_in_col[i] = W'($urandom);
    end
    a_in_valid = '1; b_in_valid = '1; drain_pulse = 1'b1; acc_clear_block = 1'b1;
    u_idle();
    u_drain_pulse = 1'b1;
    repeat (3) step();
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++) begin
        checks++;
        if (acc_mat[i][j] !== '0) begin
          errors++;
          $display("FAIL reset_acc[%0d][%0d]: got %h want 0", i, j, acc_mat[i][j]);
        end
      end
    checks++;
    if (acc_v_mat !== '0) begin
      errors++;
      $display("FAIL reset_valid: got %h want 0", acc_v_mat);
    end
    checks++;
    if (u_acc_v_mat !== '0 || u_acc_mat !== '0) begin
      errors++;
      $display("FAIL reset_unsigned_inst: valid %h acc00 %h want 0", u_acc_v_mat, u_acc_mat[0][0]);
    end
    rst = 1'b0;
    idle_inputs();
    u_idle();
    step();
  endtask

  // Compare the snapshot taken by the drain just issued, then its valid dropping.
  task automatic check_tile(input string name);
    checks++;
    if (acc_v_mat !== all_ones) begin
      errors++;
      $display("FAIL %s_valid_hi: got %h want all ones", name, acc_v_mat);
    end
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++) begin
        checks++;
        if (acc_mat[i][j] !== exp_c[i][j]) begin
          errors++;
          $display("FAIL %s[%0d][%0d]: got %h want %h", name, i, j, acc_mat[i][j], exp_c[i][j]);
        end
      end
    step();
    checks++;
    if (acc_v_mat !== '0) begin
      errors++;
      $display("FAIL %s_valid_lo: got %h want 0", name, acc_v_mat);
    end
    checks++;
    if (acc_mat[T-1][T-1] !== exp_c[T-1][T-1]) begin
      errors++;
      $display("FAIL %s_hold: got %h want %h", name, acc_mat[T-1][T-1], exp_c[T-1][T-1]);
    end
  endtask

  task automatic test_single_mac();
    clear_mats();
    a_m[0][0] = 8'd3; av_m[0][0] = 1'b1;
    b_m[0][0] = 8'd5; bv_m[0][0] = 1'b1;
    compute_model(1);
    feed_tile(1, 1'b1);
    do_drain();
    checks++;
    if (acc_mat[0][0] !== 32'd15) begin
      errors++;
      $display("FAIL single_mac_direct: got %h want 0000000f", acc_mat[0][0]);
    end
    check_tile("single_mac");
  endtask

  task automatic test_identity_ramp();
    set_identity_ramp();
    compute_model(T);
    feed_tile(T, 1'b1);
    do_drain();
    check_tile("identity_ramp");
  endtask

  task automatic test_signedness();
    clear_mats();
    a_m[0][0] = 8'hFE; av_m[0][0] = 1'b1;
    b_m[0][0] = 8'h03; bv_m[0][0] = 1'b1;
    compute_model(1);
    feed_tile(1, 1'b1);
    do_drain();
    checks++;
    if (acc_mat[0][0] !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL signed_fe_x3: got %h want fffffffa", acc_mat[0][0]);
    end
    check_tile("signed");

    // Unsigned, unpipelined instance: drain on the same edge the operands meet.
    u_idle();
    u_acc_clear_block = 1'b1;
    step();
    u_acc_clear_block = 1'b0;
    u_a_in_row[0] = 8'hFE; u_a_in_valid[0] = 1'b1;
    u_b_in_col[0] = 8'h03; u_b_in_valid[0] = 1'b1;
    u_drain_pulse = 1'b1;
    step();
    u_idle();
    checks++;
    if (u_acc_mat[0][0] !== ref_prod(8'hFE, 8'h03, 1'b0) || u_acc_v_mat !== u_all_ones) begin
      errors++;
      $display("FAIL unsigned_fe_x3: got %h v=%h want %h", u_acc_mat[0][0], u_acc_v_mat, ref_prod(8'hFE, 8'h03, 1'b0));
    end
    step();
    checks++;
    if (u_acc_v_mat !== '0 || u_acc_mat[0][0] !== 32'd762) begin
      errors++;
      $display("FAIL unsigned_hold: got %h v=%h want 762", u_acc_mat[0][0], u_acc_v_mat);
    end
    // Clear with a coincident product: accumulator restarts at that product.
    u_a_in_row[0] = 8'd2; u_a_in_valid[0] = 1'b1;
    u_b_in_col[0] = 8'd3; u_b_in_valid[0] = 1'b1;
    u_acc_clear_block = 1'b1;
    step();
    u_idle();
    u_drain_pulse = 1'b1;
    step();
    u_idle();
    checks++;
    if (u_acc_mat[0][0] !== 32'd6) begin
      errors++;
      $display("FAIL unsigned_clear_add: got %h want 6", u_acc_mat[0][0]);
    end
  endtask

  task automatic test_valid_mismatch();
    idle_inputs();
    acc_clear_block = 1'b1;
    step();
    acc_clear_block = 1'b0;
    repeat (5) begin
      a_in_row[0] = W'($urandom); a_in_valid[0] = 1'b1;
      step();
    end
    idle_inputs();
    repeat (T + 2) step();
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++) exp_c[i][j] = '0;
    do_drain();
    check_tile("a_only");

    // A enters row 0 alone; B meets it at column 3 three cycles later.
    acc_clear_block = 1'b1;
    step();
    acc_clear_block = 1'b0;
    a_in_row[0] = 8'd7; a_in_valid[0] = 1'b1;
    step();
    idle_inputs();
    step();
    step();
    b_in_col[3] = 8'd9; b_in_valid[3] = 1'b1;
    step();
    idle_inputs();
    repeat (T + 2) step();
    exp_c[0][3] = 32'd63;
    do_drain();
    check_tile("a_hop3");
  endtask

  task automatic test_clear_drain_collision();
    idle_inputs();
    acc_clear_block = 1'b1;
    step();
    acc_clear_block = 1'b0;
    a_in_row[0] = 8'd2; a_in_valid[0] = 1'b1;
    b_in_col[0] = 8'd5; b_in_valid[0] = 1'b1;
    step();
    idle_inputs();
    repeat (4) step();
    a_in_row[0] = 8'd2; a_in_valid[0] = 1'b1;
    b_in_col[0] = 8'd2; b_in_valid[0] = 1'b1;
    if (PIPE_MUL != 0) begin
      step();
      a_in_valid = '0; b_in_valid = '0;
    end
    drain_pulse = 1'b1;
    acc_clear_block = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (acc_mat[0][0] !== 32'd14) begin
      errors++;
      $display("FAIL collision_snap: got %h want 14", acc_mat[0][0]);
    end
    repeat (3) step();

    // Drain held two cycles; a 1*3 product lands on the second drain edge.
    drain_pulse = 1'b1;
    if (PIPE_MUL != 0) begin
      a_in_row[0] = 8'd1; a_in_valid[0] = 1'b1;
      b_in_col[0] = 8'd3; b_in_valid[0] = 1'b1;
    end
    step();
    checks++;
    if (acc_mat[0][0] !== 32'd4 || acc_v_mat !== all_ones) begin
      errors++;
      $display("FAIL b2b_first: got %h v0=%b want 4 with valid", acc_mat[0][0], acc_v_mat[0][0]);
    end
    if (PIPE_MUL != 0) begin
      a_in_valid = '0; b_in_valid = '0;
    end else begin
      a_in_row[0] = 8'd1; a_in_valid[0] = 1'b1;
      b_in_col[0] = 8'd3; b_in_valid[0] = 1'b1;
    end
    step();
    idle_inputs();
    checks++;
    if (acc_mat[0][0] !== 32'd7 || acc_v_mat !== all_ones) begin
      errors++;
      $display("FAIL b2b_second: got %h v0=%b want 7 with valid", acc_mat[0][0], acc_v_mat[0][0]);
    end
    step();
    checks++;
    if (acc_v_mat !== '0) begin
      errors++;
      $display("FAIL b2b_valid_lo: got %h want 0", acc_v_mat);
    end
  endtask

  task automatic test_random_tiles();
    int k_len;
    for (int r = 0; r < 4; r++) begin
      clear_mats();
      k_len = $urandom_range(1, KMAX);
      for (int i = 0; i < T; i++)
        for (int k = 0; k < k_len; k++) begin
          a_m[i][k] = W'($urandom); av_m[i][k] = ($urandom_range(0, 3) != 0);
          b_m[k][i] = W'($urandom); bv_m[k][i] = ($urandom_range(0, 3) != 0);
        end
      compute_model(k_len);
      feed_tile(k_len, 1'b1);
      do_drain();
      check_tile("random_tile");
    end
  endtask

  task automatic test_reset_mid();
    set_identity_ramp();
    idle_inputs();
    acc_clear_block = 1'b1;
    step();
    acc_clear_block = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive_cycle(c, T);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++) begin
        checks++;
        if (acc_mat[i][j] !== '0) begin
          errors++;
          $display("FAIL midreset_acc[%0d][%0d]: got %h want 0", i, j, acc_mat[i][j]);
        end
      end
    checks++;
    if (acc_v_mat !== '0) begin
      errors++;
      $display("FAIL midreset_valid: got %h want 0", acc_v_mat);
    end
    repeat (T + 2) step();
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++) exp_c[i][j] = '0;
    do_drain();
    check_tile("midreset_empty");
    // Rerun without a clear: only reset can have emptied the accumulators.
    compute_model(T);
    feed_tile(T, 1'b0);
    do_drain();
    check_tile("midreset_rerun");
  endtask

  initial begin
    all_ones   = '1;
    u_all_ones = '1;
    rst = 1'b1;
    idle_inputs();
    u_idle();
    test_reset();
    test_single_mac();
    test_identity_ramp();
    test_signedness();
    test_valid_mismatch();
    test_clear_drain_collision();
    test_random_tiles();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
